// File: rtl/deserializer.sv
// Word-to-frame deserializer: gathers N WIDTH-bit words (word 0 flagged by I_sof) into one
// parallel frame with valid/ready output. Define DESERIALIZER_ERR_EN for err/err_cnt ports.
module deserializer_slot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end
endmodule

module deserializer #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          I,
  input  logic                      I_valid,
  input  logic                      I_sof,
  output logic                      I_ready,
`ifdef DESERIALIZER_ERR_EN
  output logic                      err,
  output logic [7:0]                err_cnt,
`endif
  output logic [N-1:0][WIDTH-1:0]   O,
  output logic                      O_valid,
  input  logic                      O_ready
);
  localparam int IW = (N > 2) ? $clog2(N) : 1;

  typedef enum logic {SYNC, COLLECT} state_t;

  state_t                   state;
  logic [IW-1:0]            idx;
  logic [N-2:0][WIDTH-1:0]  slots;
  logic [N-2:0]             slot_ld;
  logic                     last, stall, beat;

  assign last    = (state == COLLECT) && (idx == IW'(N-1));
  // Only the completing word waits on the output register; earlier words never stall.
  assign stall   = last && O_valid && !O_ready;
  assign I_ready = !rst && !stall;
  assign beat    = I_valid && I_ready;

  // Slot 0 takes every sof word (also restarts a broken frame); slot k takes word k.
  for (genvar k = 0; k < N-1; k++) begin : g_slot
    if (k == 0) begin : g_first
      assign slot_ld[k] = beat && I_sof;
    end else begin : g_rest
      assign slot_ld[k] = beat && !I_sof && (state == COLLECT) && (idx == IW'(k));
    end
    deserializer_slot #(.WIDTH(WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .ld  (slot_ld[k]),
      .d   (I),
      .q   (slots[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= SYNC;
      idx     <= '0;
      O       <= '0;
      O_valid <= 1'b0;
    end else begin
      if (O_valid && O_ready) O_valid <= 1'b0;
      if (beat) begin
        if (I_sof) begin
          state <= COLLECT;
          idx   <= IW'(1);
        end else if (state == COLLECT) begin
          if (idx == '0) begin
            state <= SYNC;
          end else if (last) begin
            // Completion overrides the take above, so a drained register reloads bubble-free.
            O       <= {I, slots};
            O_valid <= 1'b1;
            idx     <= '0;
          end else begin
            idx <= idx + IW'(1);
          end
        end
      end
    end
  end

`ifdef DESERIALIZER_ERR_EN
  logic align_err;

  // Misplaced sof, or a headless word right after a completed frame.
  assign align_err = beat && (state == COLLECT) && (I_sof ? (idx != '0) : (idx == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      err     <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      err <= align_err;
      if (align_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed scenarios plus random traffic against a
// queue-based frame model. Error port checks apply when DESERIALIZER_ERR_EN is defined.
module tb_deserializer;
  localparam int WIDTH = 16;
  localparam int N     = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [WIDTH-1:0]        I = '0;
  logic                    I_valid = 1'b0;
  logic                    I_sof = 1'b0;
  logic                    I_ready;
  logic [N-1:0][WIDTH-1:0] O;
  logic                    O_valid;
  logic                    O_ready = 1'b0;
`ifdef DESERIALIZER_ERR_EN
  logic                    err;
  logic [7:0]              err_cnt;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  deserializer #(.WIDTH(WIDTH), .N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .I       (I),
    .I_valid (I_valid),
    .I_sof   (I_sof),
    .I_ready (I_ready),
`ifdef DESERIALIZER_ERR_EN
    .err     (err),
    .err_cnt (err_cnt),
`endif
    .O       (O),
    .O_valid (O_valid),
    .O_ready (O_ready)
  );

  // Reference: words of the frame in progress, sync flag, one-deep output holding register.
  logic [WIDTH-1:0]        part[$];
  bit                      synced;
  bit                      m_full;
  logic [N-1:0][WIDTH-1:0] m_out;
  bit                      m_err;
  int                      m_cnt;

  function automatic bit m_ready(input bit r);
    return !(synced && part.size() == N-1 && m_full && !r);
  endfunction

  task automatic model_reset();
    part.delete();
    synced = 0; m_full = 0; m_out = '0; m_err = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit b, input bit s, input logic [WIDTH-1:0] d, input bit r);
    m_err = 0;
    if (m_full && r) m_full = 0;
    if (b) begin
      if (s) begin
        if (synced && part.size() != 0) m_err = 1;
        part.delete();
        part.push_back(d);
        synced = 1;
      end else if (synced) begin
        if (part.size() == 0) begin
          m_err  = 1;
          synced = 0;
        end else begin
          part.push_back(d);
          if (part.size() == N) begin
            for (int i = 0; i < N; i++) m_out[i] = part[i];
            m_full = 1;
            part.delete();
          end
        end
      end
    end
    if (m_err && m_cnt < 255) m_cnt++;
  endtask

  // Drive one cycle of stimulus, then compare every output against the model.
  task automatic cycle(input bit v, input bit s, input logic [WIDTH-1:0] d, input bit r);
    bit er;
    I_valid = v; I_sof = s; I = d; O_ready = r;
    #1;
    er = m_ready(r);
    compared++;
    if (I_ready !== er) begin
      mismatched++;
      $display("FAIL i_ready: got %b expected %b at %0t", I_ready, er, $time);
    end
    model_step(v && er, s, d, r);
    @(posedge clk); #1;
    compared++;
    if (O_valid !== m_full) begin
      mismatched++;
      $display("FAIL o_valid: got %b expected %b at %0t", O_valid, m_full, $time);
    end
    compared++;
    if (O !== m_out) begin
      mismatched++;
      $display("FAIL o_data: got %h expected %h at %0t", O, m_out, $time);
    end
`ifdef DESERIALIZER_ERR_EN
    compared++;
    if (err !== m_err || err_cnt !== 8'(m_cnt)) begin
      mismatched++;
      $display("FAIL err: got %b/%0d expected %b/%0d at %0t", err, err_cnt, m_err, m_cnt, $time);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1; I_valid = 0; I_sof = 0; O_ready = 0;
    #1;
    compared++;
    if (I_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_i_ready: got %b expected 0", I_ready);
    end
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    compared++;
    if (O_valid !== 1'b0 || O !== '0) begin
      mismatched++;
      $display("FAIL reset_out: got valid %b data %h expected 0/0", O_valid, O);
    end
`ifdef DESERIALIZER_ERR_EN
    compared++;
    if (err_cnt !== 8'd0) begin
      mismatched++;
      $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
    end
`endif
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] base, input bit r);
    for (int i = 0; i < N; i++) cycle(1, i == 0, base + WIDTH'(i), r);
  endtask

  task automatic test_single();
    logic [N-1:0][WIDTH-1:0] exp_f;
    exp_f = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    cycle(1, 1, 16'h1111, 1);
    cycle(1, 0, 16'h2222, 1);
    cycle(1, 0, 16'h3333, 1);
    cycle(1, 0, 16'h4444, 1);
    compared++;
    if (O_valid !== 1'b1 || O !== exp_f) begin
      mismatched++;
      $display("FAIL single_frame: got %b/%h expected 1/%h", O_valid, O, exp_f);
    end
    cycle(0, 0, '0, 1);
    compared++;
    if (O_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL single_clear: got %b expected 0", O_valid);
    end
  endtask

  task automatic test_back_to_back();
    int frames = 0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) begin
        cycle(1, i == 0, WIDTH'(16'h0100 * (f + 1) + i), 1);
        if (O_valid) frames++;
      end
    compared++;
    if (frames !== 3) begin
      mismatched++;
      $display("FAIL b2b_count: got %0d expected 3", frames);
    end
    cycle(0, 0, '0, 1);
  endtask

  task automatic test_stall();
    logic [N-1:0][WIDTH-1:0] exp_b;
    exp_b = {16'hB003, 16'hB002, 16'hB001, 16'hB000};
    send_frame(16'hA000, 0);
    for (int i = 0; i < N-1; i++) cycle(1, i == 0, 16'hB000 + WIDTH'(i), 0);
    for (int k = 0; k < 3; k++) begin
      I_valid = 1; I_sof = 0; I = 16'hB003; O_ready = 0;
      #1;
      compared++;
      if (I_ready !== 1'b0) begin
        mismatched++;
        $display("FAIL stall_ready: got %b expected 0", I_ready);
      end
      cycle(1, 0, 16'hB003, 0);
    end
    cycle(1, 0, 16'hB003, 1);
    compared++;
    if (O_valid !== 1'b1 || O !== exp_b) begin
      mismatched++;
      $display("FAIL stall_reload: got %b/%h expected 1/%h", O_valid, O, exp_b);
    end
    cycle(0, 0, '0, 1);
  endtask

  task automatic test_presync_drop();
    test_reset();
    cycle(1, 0, 16'hAAAA, 1);
    cycle(1, 0, 16'hBBBB, 1);
    send_frame(16'hC000, 1);
    compared++;
    if (O !== {16'hC003, 16'hC002, 16'hC001, 16'hC000}) begin
      mismatched++;
      $display("FAIL presync_frame: got %h expected c003c002c001c000", O);
    end
    cycle(0, 0, '0, 1);
  endtask

  task automatic test_resync();
    test_reset();
    cycle(1, 1, 16'h0001, 1);
    cycle(1, 0, 16'h0002, 1);
    send_frame(16'h0010, 1);
    compared++;
    if (O_valid !== 1'b1 || O !== {16'h0013, 16'h0012, 16'h0011, 16'h0010}) begin
      mismatched++;
      $display("FAIL resync_frame: got %b/%h expected 1/0013001200110010", O_valid, O);
    end
`ifdef DESERIALIZER_ERR_EN
    compared++;
    if (err_cnt !== 8'd1) begin
      mismatched++;
      $display("FAIL resync_err_cnt: got %0d expected 1", err_cnt);
    end
`endif
    cycle(0, 0, '0, 1);
  endtask

  task automatic test_mid_reset();
    send_frame(16'hD000, 0);
    cycle(1, 1, 16'hE000, 0);
    cycle(1, 0, 16'hE001, 0);
    test_reset();
    send_frame(16'hF000, 1);
    cycle(0, 0, '0, 1);
  endtask

  task automatic test_err_saturate();
    test_reset();
    for (int i = 0; i < 300; i++) cycle(1, 1, WIDTH'(i), 1);
`ifdef DESERIALIZER_ERR_EN
    compared++;
    if (err_cnt !== 8'd255) begin
      mismatched++;
      $display("FAIL err_saturate: got %0d expected 255", err_cnt);
    end
`endif
  endtask

  task automatic test_random();
    int k = 0;
    bit v, s, r, acc;
    test_reset();
    for (int c = 0; c < 3000; c++) begin
      v   = $urandom_range(0, 9) < 7;
      r   = $urandom_range(0, 9) < 6;
      s   = (k == 0) ^ ($urandom_range(0, 24) == 0);
      acc = v && m_ready(r);
      cycle(v, s, WIDTH'($urandom), r);
      if (acc) k = (k + 1) % N;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_presync_drop();
    test_resync();
    test_mid_reset();
    test_err_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
